// File: rtl/jtframe_neptuno_joy.sv
// NeptUNO serial joystick scanner: walks the 74HC165 chain in two select
// phases and publishes glitch-filtered, active-low button words per player.
module jtframe_neptuno_joy #(
    parameter int HALF   = 4,
    parameter int SETTLE = 32,
    parameter int PERIOD = 48000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    output logic        JOY_SELECT,
    input  logic        JOY_DATA,
    output logic [15:0] joy1,
    output logic [15:0] joy2,
    output logic        scan_done
);
    localparam int CMAX = (SETTLE > HALF) ? SETTLE : HALF;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(PERIOD + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETTLE, ST_LOAD, ST_SHLO, ST_SHHI, ST_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] p1;
        logic [15:0] p2;
    } scan_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    bitcnt;
    logic          phase;
    logic [TW-1:0] timer;
    logic [1:0]    sync_pipe;
    logic [15:0]   sr0, sr1;
    scan_t         raw, prev;
    logic          data_s, start, half_end, settle_end;

    assign data_s     = sync_pipe[1];
    assign start      = (state == ST_IDLE) && scan_en && (timer == '0);
    assign half_end   = (cnt == CW'(HALF - 1));
    assign settle_end = (cnt == CW'(SETTLE - 1));
    // sr[15:8] holds the player 1 byte (first eight bits out), sr[7:0] player 2
    assign raw = {sr1[15:8], sr0[15:8], sr1[7:0], sr0[7:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_pipe <= 2'b11;
        else     sync_pipe <= {sync_pipe[0], JOY_DATA};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           timer <= '0;
        else if (start)                    timer <= TW'(PERIOD - 1);
        else if (scan_en && timer != '0)   timer <= timer - TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            phase      <= 1'b0;
            JOY_CLK    <= 1'b0;
            JOY_LOAD   <= 1'b1;
            JOY_SELECT <= 1'b1;
            scan_done  <= 1'b0;
            sr0        <= '1;
            sr1        <= '1;
            prev       <= '1;
            joy1       <= '1;
            joy2       <= '1;
        end else begin
            scan_done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    state      <= ST_SETTLE;
                    phase      <= 1'b0;
                    cnt        <= '0;
                    JOY_SELECT <= 1'b1;
                end
                ST_SETTLE: if (settle_end) begin
                    state    <= ST_LOAD;
                    cnt      <= '0;
                    JOY_LOAD <= 1'b0;
                end else cnt <= cnt + CW'(1);
                ST_LOAD: if (half_end) begin
                    state    <= ST_SHLO;
                    cnt      <= '0;
                    bitcnt   <= '0;
                    JOY_LOAD <= 1'b1;
                end else cnt <= cnt + CW'(1);
                ST_SHLO: if (half_end) begin
                    if (!phase) sr0 <= {sr0[14:0], data_s};
                    else        sr1 <= {sr1[14:0], data_s};
                    state   <= ST_SHHI;
                    cnt     <= '0;
                    JOY_CLK <= 1'b1;
                end else cnt <= cnt + CW'(1);
                ST_SHHI: if (half_end) begin
                    cnt     <= '0;
                    JOY_CLK <= 1'b0;
                    if (bitcnt == 4'd15) begin
                        if (!phase) begin
                            phase      <= 1'b1;
                            state      <= ST_SETTLE;
                            JOY_SELECT <= 1'b0;
                        end else begin
                            state     <= ST_DONE;
                            scan_done <= 1'b1;
                        end
                    end else begin
                        bitcnt <= bitcnt + 4'd1;
                        state  <= ST_SHLO;
                    end
                end else cnt <= cnt + CW'(1);
                ST_DONE: begin
                    // publish only when two consecutive scans agree
                    if (raw == prev) begin
                        joy1 <= raw.p1;
                        joy2 <= raw.p2;
                    end
                    prev       <= raw;
                    state      <= ST_IDLE;
                    JOY_SELECT <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_neptuno_joy.sv
// Bench for jtframe_neptuno_joy: 74HC165 chain models feed two instances
// (slow period and back-to-back) checked against a per-scan filter model.
module tb_jtframe_neptuno_joy;
    localparam int HALF_A = 4, SETTLE_A = 32, PERIOD_A = 1000;
    localparam int HALF_B = 3, SETTLE_B = 8,  PERIOD_B = 100;
    localparam int PH_A   = SETTLE_A + HALF_A + 32 * HALF_A;
    localparam int PH_B   = SETTLE_B + HALF_B + 32 * HALF_B;

    logic clk = 1'b0, rst = 1'b1, en_a = 1'b0, en_b = 1'b0;
    logic jclk_a, jload_a, jsel_a, jdat_a, sd_a;
    logic jclk_b, jload_b, jsel_b, jdat_b, sd_b;
    logic [15:0] j1_a, j2_a, j1_b, j2_b;
    int n_cmp = 0, n_err = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtframe_neptuno_joy #(.HALF(HALF_A), .SETTLE(SETTLE_A), .PERIOD(PERIOD_A)) dut_a (
        .clk(clk), .rst(rst), .scan_en(en_a), .JOY_CLK(jclk_a), .JOY_LOAD(jload_a),
        .JOY_SELECT(jsel_a), .JOY_DATA(jdat_a), .joy1(j1_a), .joy2(j2_a), .scan_done(sd_a));

    jtframe_neptuno_joy #(.HALF(HALF_B), .SETTLE(SETTLE_B), .PERIOD(PERIOD_B)) dut_b (
        .clk(clk), .rst(rst), .scan_en(en_b), .JOY_CLK(jclk_b), .JOY_LOAD(jload_b),
        .JOY_SELECT(jsel_b), .JOY_DATA(jdat_b), .joy1(j1_b), .joy2(j2_b), .scan_done(sd_b));

    // Pad words per select level: {player1 byte, player2 byte}
    logic [15:0] w1_a = 16'hFFFF, w0_a = 16'hFFFF, sh_a = 16'hFFFF;
    logic [15:0] w1_b = 16'hA55A, w0_b = 16'h0FF0, sh_b = 16'hFFFF;

    always @(negedge jload_a or posedge jclk_a)
        if (!jload_a) sh_a <= jsel_a ? w1_a : w0_a;
        else          sh_a <= {sh_a[14:0], 1'b1};
    always @(negedge jload_b or posedge jclk_b)
        if (!jload_b) sh_b <= jsel_b ? w1_b : w0_b;
        else          sh_b <= {sh_b[14:0], 1'b1};
    assign jdat_a = sh_a[15];
    assign jdat_b = sh_b[15];

    // Reference: a scan yields {joy1, joy2}; outputs follow only on two equal scans
    logic [31:0] raw_a, raw_b, prev_a, prev_b, exp_a, exp_b;
    assign raw_a = {w0_a[15:8], w1_a[15:8], w0_a[7:0], w1_a[7:0]};
    assign raw_b = {w0_b[15:8], w1_b[15:8], w0_b[7:0], w1_b[7:0]};

    always @(negedge clk or posedge rst)
        if (rst) begin
            prev_a <= '1; exp_a <= '1; prev_b <= '1; exp_b <= '1;
        end else begin
            if (sd_a) begin
                if (raw_a == prev_a) exp_a <= raw_a;
                prev_a <= raw_a;
            end
            if (sd_b) begin
                if (raw_b == prev_b) exp_b <= raw_b;
                prev_b <= raw_b;
            end
        end

    int m_fall[2], m_len[2], m_rise[2], m_sel[2];
    int m_nl, m_done, m_t0;
    bit m_ok;

    task automatic measure_scan();
        bit pl, pc;
        m_nl = 0; m_ok = 0; m_done = -1; m_t0 = -1;
        for (int k = 0; k < 2; k++) begin
            m_fall[k] = -1; m_len[k] = 0; m_rise[k] = 0; m_sel[k] = -1;
        end
        pl = jload_a; pc = jclk_a;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (pl && !jload_a) begin
                if (m_nl < 2) begin m_fall[m_nl] = c; m_sel[m_nl] = int'(jsel_a); end
                if (m_nl == 0) m_t0 = cyc;
                m_nl++;
            end
            if (!jload_a && m_nl >= 1 && m_nl <= 2) m_len[m_nl-1]++;
            if (!pc && jclk_a && m_nl >= 1 && m_nl <= 2) m_rise[m_nl-1]++;
            pl = jload_a; pc = jclk_a;
            if (sd_a) begin m_done = c; m_ok = 1; break; end
        end
    endtask

    task automatic wait_done_a(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sd_a) begin ok = 1; break; end
        end
    endtask

    task automatic wait_done_b(input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (sd_b) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        logic [35:0] want;
        want = {1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        #12;
        n_cmp++;
        if ({jclk_a, jload_a, jsel_a, j1_a, j2_a, sd_a} !== want) begin
            n_err++; $display("FAIL reset_a: got %h want %h", {jclk_a, jload_a, jsel_a, j1_a, j2_a, sd_a}, want);
        end
        n_cmp++;
        if ({jclk_b, jload_b, jsel_b, j1_b, j2_b, sd_b} !== want) begin
            n_err++; $display("FAIL reset_b: got %h want %h", {jclk_b, jload_b, jsel_b, j1_b, j2_b, sd_b}, want);
        end
        @(negedge clk);
        rst = 1'b0; en_a = 1'b1; en_b = 1'b1;
    endtask

    task automatic test_idle_chain();
        measure_scan();
        n_cmp++;
        if (m_ok !== 1'b1 || m_nl != 2) begin n_err++; $display("FAIL idle_scan: done %0d loads %0d want 1 and 2", m_ok, m_nl); end
        n_cmp++;
        if (m_done - m_fall[0] + SETTLE_A + 1 != 329) begin
            n_err++; $display("FAIL idle_scan_len: got %0d want 329", m_done - m_fall[0] + SETTLE_A + 1);
        end
        n_cmp++;
        if (m_fall[1] - m_fall[0] != PH_A) begin n_err++; $display("FAIL phase_len: got %0d want %0d", m_fall[1] - m_fall[0], PH_A); end
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (m_len[k] != HALF_A) begin n_err++; $display("FAIL load_len%0d: got %0d want %0d", k, m_len[k], HALF_A); end
            n_cmp++;
            if (m_rise[k] != 16) begin n_err++; $display("FAIL clk_rises%0d: got %0d want 16", k, m_rise[k]); end
            n_cmp++;
            if (m_sel[k] != 1 - k) begin n_err++; $display("FAIL select%0d: got %0d want %0d", k, m_sel[k], 1 - k); end
        end
        @(negedge clk);
        n_cmp++;
        if ({j1_a, j2_a} !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL idle_joy: got %h want ffffffff", {j1_a, j2_a}); end
    endtask

    task automatic test_pattern();
        bit ok;
        w1_a = {8'h5A, 8'hC3};
        w0_a = {8'h3F, 8'hF0};
        wait_done_a(1500, ok);
        n_cmp++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL pattern_done1: got %0d want 1", ok); end
        @(negedge clk);
        n_cmp++;
        if ({j1_a, j2_a} !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL pattern_first: got %h want ffffffff", {j1_a, j2_a}); end
        wait_done_a(1500, ok);
        n_cmp++;
        if (ok !== 1'b1 || {j1_a, j2_a} !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL pattern_at_done: done %0d joy %h want 1 ffffffff", ok, {j1_a, j2_a});
        end
        @(negedge clk);
        n_cmp++;
        if (j1_a !== 16'h3F5A || j2_a !== 16'hF0C3) begin n_err++; $display("FAIL pattern_second: got %h %h want 3f5a f0c3", j1_a, j2_a); end
    endtask

    task automatic test_glitch();
        bit ok;
        w1_a = {8'h5B, 8'hC3};
        wait_done_a(1500, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || j1_a !== 16'h3F5A) begin n_err++; $display("FAIL glitch_once: done %0d joy1 %h want 1 3f5a", ok, j1_a); end
        wait_done_a(1500, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || j1_a !== 16'h3F5B) begin n_err++; $display("FAIL glitch_twice: done %0d joy1 %h want 1 3f5b", ok, j1_a); end
    endtask

    task automatic test_random();
        bit ok;
        int reps;
        for (int it = 0; it < 8; it++) begin
            if (it % 2 == 0) begin
                w0_a = 16'($urandom); w1_a = 16'($urandom);
            end else begin
                w1_a[$urandom_range(0, 15)] ^= 1'b1;
            end
            reps = $urandom_range(1, 2);
            for (int r = 0; r < reps; r++) begin
                wait_done_a(1500, ok);
                @(negedge clk);
                n_cmp++;
                if (ok !== 1'b1 || {j1_a, j2_a} !== exp_a) begin
                    n_err++; $display("FAIL random%0d_%0d: done %0d joy %h want %h", it, r, ok, {j1_a, j2_a}, exp_a);
                end
            end
        end
    endtask

    task automatic test_period();
        int t_first;
        measure_scan();
        t_first = m_t0;
        @(negedge clk);
        measure_scan();
        @(negedge clk);
        n_cmp++;
        if (m_ok !== 1'b1 || m_t0 - t_first != PERIOD_A) begin
            n_err++; $display("FAIL period: done %0d spacing %0d want 1 %0d", m_ok, m_t0 - t_first, PERIOD_A);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int t_d, gap;
        wait_done_b(400, ok);
        t_d = cyc;
        gap = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!jload_b) begin gap = cyc - t_d; break; end
        end
        n_cmp++;
        if (ok !== 1'b1 || gap != SETTLE_B + 2) begin n_err++; $display("FAIL b2b_gap: done %0d gap %0d want 1 %0d", ok, gap, SETTLE_B + 2); end
        wait_done_b(400, ok);
        n_cmp++;
        if (ok !== 1'b1 || cyc - t_d != 2 * PH_B + 2) begin
            n_err++; $display("FAIL b2b_spacing: done %0d got %0d want %0d", ok, cyc - t_d, 2 * PH_B + 2);
        end
        @(negedge clk);
        n_cmp++;
        if ({j1_b, j2_b} !== 32'h0FA5_F05A) begin n_err++; $display("FAIL b2b_joy: got %h want 0fa5f05a", {j1_b, j2_b}); end
        w0_b = 16'($urandom); w1_b = 16'($urandom);
        wait_done_b(400, ok);
        wait_done_b(400, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || {j1_b, j2_b} !== exp_b) begin n_err++; $display("FAIL b2b_new: done %0d got %h want %h", ok, {j1_b, j2_b}, exp_b); end
    endtask

    task automatic test_enable_drop();
        bit ok, seen;
        int loads, sels, dones;
        seen = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (!jload_a) begin seen = 1; break; end
        end
        en_a = 1'b0;
        wait_done_a(600, ok);
        n_cmp++;
        if (seen !== 1'b1 || ok !== 1'b1) begin n_err++; $display("FAIL drop_completes: load %0d done %0d want 1 1", seen, ok); end
        @(negedge clk);
        n_cmp++;
        if ({j1_a, j2_a} !== exp_a) begin n_err++; $display("FAIL drop_filter: got %h want %h", {j1_a, j2_a}, exp_a); end
        loads = 0; sels = 0; dones = 0;
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if (!jload_a) loads++;
            if (!jsel_a) sels++;
            if (sd_a) dones++;
        end
        n_cmp++;
        if (loads != 0 || sels != 0 || dones != 0) begin
            n_err++; $display("FAIL drop_idle: loads %0d sel_low %0d dones %0d want 0 0 0", loads, sels, dones);
        end
    endtask

    task automatic test_reset_mid_scan();
        bit ok, hi;
        int dones, loads;
        logic [35:0] want;
        w1_a = 16'h1234; w0_a = 16'h5678;
        en_a = 1'b1;
        wait_done_a(1500, ok);
        wait_done_a(1500, ok);
        @(negedge clk);
        n_cmp++;
        if (ok !== 1'b1 || {j1_a, j2_a} !== 32'h5612_7834) begin
            n_err++; $display("FAIL pre_reset_joy: done %0d got %h want 56127834", ok, {j1_a, j2_a});
        end
        hi = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (jclk_a) begin hi = 1; break; end
        end
        #1 rst = 1'b1;
        #1;
        want = {1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b0};
        n_cmp++;
        if (hi !== 1'b1 || {jclk_a, jload_a, jsel_a, j1_a, j2_a, sd_a} !== want) begin
            n_err++; $display("FAIL reset_mid_shhi: seen %0d got %h want %h", hi, {jclk_a, jload_a, jsel_a, j1_a, j2_a, sd_a}, want);
        end
        en_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        dones = 0; loads = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sd_a) dones++;
            if (!jload_a) loads++;
        end
        n_cmp++;
        if (dones != 0 || loads != 0 || {j1_a, j2_a} !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL post_reset: dones %0d loads %0d joy %h want 0 0 ffffffff", dones, loads, {j1_a, j2_a});
        end
    endtask

    initial begin
        test_reset();
        test_idle_chain();
        test_pattern();
        test_glitch();
        test_random();
        test_period();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/jtframe_neptuno_joy.md
# jtframe_neptuno_joy

NeptUNO serial joystick scanner. Drives the board's parallel-in/serial-out joystick shift-register chain (JOY_CLK, JOY_LOAD, JOY_SELECT, JOY_DATA) and reads two Megadrive-style pads in two select phases. It delivers filtered, active-low raw button words for players 1 and 2. It sits directly upstream of the NeptUNO frame input logic, which maps these words onto game_joystick1/2.

## Interface
Parameters:
- HALF, 4: clk cycles per JOY_CLK half-period; minimum 3.
- SETTLE, 32: clk cycles JOY_SELECT is held before each parallel load.
- PERIOD, 48000: clk cycles between scan starts (1 ms at 48 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- scan_en  in  1  scanning enable.
- JOY_CLK  out  1  shift clock to the chain.
- JOY_LOAD  out  1  parallel load, active-low.
- JOY_SELECT  out  1  pad select line.
- JOY_DATA  in  1  serial data from the chain, asynchronous.
- joy1  out  16  player 1 buttons, active-low. [7:0] is the SELECT=1 byte; [15:8] is the SELECT=0 byte.
- joy2  out  16  player 2, same layout.
- scan_done  out  1  one-cycle pulse at the end of every complete scan.

## Operation
- JOY_DATA passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- States: IDLE, SETTLE, LOAD, SHLO, SHHI, DONE.
- A 1-bit phase register selects the phase: phase 0 drives JOY_SELECT=1, phase 1 drives JOY_SELECT=0.
- IDLE leaves when scan_en=1 and the period timer is 0. It enters SETTLE with phase=0.
- SETTLE: drive JOY_SELECT for the current phase and hold for SETTLE cycles, then go to LOAD.
- LOAD: JOY_LOAD=0 for HALF cycles with JOY_CLK=0, then go to SHLO with bit counter=0.
- SHLO: JOY_CLK=0 for HALF cycles. On the last cycle, sample the bit into the phase shift register, then go to SHHI.
- SHHI: JOY_CLK=1 for HALF cycles. Then increment the bit counter. If bit counter=16, the phase ends; otherwise go back to SHLO.
- At the end of phase 0, set phase=1 and go to SETTLE. At the end of phase 1, go to DONE.
- Bit order within a phase: sample k=0..7 → player 1 byte bit 7-k; sample k=8..15 → player 2 byte bit 15-k (MSB first).
- DONE lasts 1 cycle. It pulses scan_done, applies the glitch filter, and goes to IDLE. JOY_SELECT returns to 1 in IDLE.
- Glitch filter: the 32-bit raw scan is compared against the previous raw scan. joy1/joy2 update only when the two scans are equal. The current raw scan always becomes the new previous scan. The previous-scan register resets to all ones.
- Period timer: loads PERIOD-1 when a scan starts and decrements to 0 while scan_en=1. If PERIOD is shorter than the scan length, the next scan starts on the cycle after DONE.
- scan_en low mid-scan: the current scan completes, including scan_done and the filter. The block then stays in IDLE.

## Timing
- Reset values: JOY_CLK=0, JOY_LOAD=1, JOY_SELECT=1, joy1=joy2=16'hFFFF, scan_done=0, state=IDLE, timer=0, previous scan=all ones.
- Phase length is SETTLE + HALF + 32·HALF cycles; with defaults that is 164 cycles.
- Full scan is 2 × phase length + 1 (DONE); with defaults, 329 cycles from leaving IDLE to the scan_done pulse.
- Outputs are registered and change on the cycle after DONE, coincident with the scan_done pulse going low.
- JOY_DATA must be stable at least 3 clk before the end of each JOY_CLK low half-period. HALF≥3 guarantees this for data changing at the JOY_CLK rising edge.
- Each phase has exactly 16 JOY_CLK rising edges and one JOY_LOAD low pulse of HALF cycles.
- Asynchronous reset at any point returns all outputs to their reset values immediately. The partial scan is discarded.

## Test plan
- Reset: assert rst mid-SHHI → JOY_CLK=0, JOY_LOAD=1, JOY_SELECT=1, joy1=joy2=FFFF immediately. No scan_done follows.
- Idle chain: 74HC165 model with all ones, defaults → scan_done 329 cycles after the first JOY_LOAD phase begins. Each phase shows 16 JOY_CLK rises and a 4-cycle JOY_LOAD low. joy stays FFFF.
- Pattern: chain returns 0x5A,0xC3 with SELECT=1 and 0x3F,0xF0 with SELECT=0 on two consecutive scans. After the 1st scan_done, outputs are still FFFF. After the 2nd, joy1=16'h3F5A and joy2=16'hF0C3.
- Glitch: after stable 0x3F5A, one scan flips p1 bit 0 → joy1 unchanged. Two scans with the flip → joy1=16'h3F5B.
- Enable drop: deassert scan_en during phase 0 → that scan completes with scan_done. JOY_SELECT returns to 1 and no further JOY_LOAD pulses occur.
- Period: PERIOD=1000 → JOY_LOAD falling edges at phase 0 are 1000 cycles apart. PERIOD=100 → scans run back-to-back, 1 IDLE cycle between DONE and SETTLE.
